// File: rtl/pa_hazard_pkg.sv
// pa_hazard_pkg: forwarding select codes and hazard FSM state encoding
package pa_hazard_pkg;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_EX  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b11;
    typedef enum logic {IDLE = 1'b0, STALL = 1'b1} state_t;
endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// hazard_ctrl_unit_if: pipeline-side signals seen and driven by the hazard controller
interface hazard_ctrl_unit_if #(parameter int NSRC = 2, parameter int AW = 5, parameter int CNT_W = 16);
    logic                ex_rf_le, mem_rf_le, wb_rf_le;
    logic [AW-1:0]       ex_rd, mem_rd, wb_rd;
    logic                ex_load;
    logic [NSRC*AW-1:0]  id_rs;
    logic [NSRC-1:0]     id_sr;
    logic                mem_busy, flush, clr_stats;
    logic                pc_le, id_le, pipe_le, nop;
    logic [2*NSRC-1:0]   fwd_sel;
    logic [CNT_W-1:0]    bubble_cnt;
    modport master (
        output ex_rf_le, mem_rf_le, wb_rf_le, ex_rd, mem_rd, wb_rd, ex_load, id_rs, id_sr,
               mem_busy, flush, clr_stats,
        input  pc_le, id_le, pipe_le, nop, fwd_sel, bubble_cnt
    );
    modport slave (
        input  ex_rf_le, mem_rf_le, wb_rf_le, ex_rd, mem_rd, wb_rd, ex_load, id_rs, id_sr,
               mem_busy, flush, clr_stats,
        output pc_le, id_le, pipe_le, nop, fwd_sel, bubble_cnt
    );
endinterface

// File: rtl/fwd_sel_enc.sv
// fwd_sel_enc: forwarding source select for one ID operand, EX > MEM > WB > RF
module fwd_sel_enc import pa_hazard_pkg::*; #(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs,
    input  logic          sr,
    input  logic          ex_le,
    input  logic          mem_le,
    input  logic          wb_le,
    input  logic [AW-1:0] ex_rd,
    input  logic [AW-1:0] mem_rd,
    input  logic [AW-1:0] wb_rd,
    output logic [1:0]    sel
);
    logic live;
    assign live = sr & (|rs);
    always_comb
        sel = !live                    ? FWD_RF  :
              (ex_le  && ex_rd  == rs) ? FWD_EX  :
              (mem_le && mem_rd == rs) ? FWD_MEM :
              (wb_le  && wb_rd  == rs) ? FWD_WB  : FWD_RF;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: forwarding selects, load-use bubble FSM, memory freeze and bubble statistics
module hazard_ctrl_unit import pa_hazard_pkg::*; #(
    parameter int NSRC     = 2,
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               rst_n,
    hazard_ctrl_unit_if.slave bus
);
    localparam int CW = $clog2(LOAD_LAT) + 1;
    logic [NSRC-1:0]   hit;
    logic [2*NSRC-1:0] fwd;
    logic              hazard, stall_req, busy;
    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]  bubble_q;
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        logic [AW-1:0] rs;
        assign rs     = bus.id_rs[i*AW +: AW];
        assign hit[i] = bus.id_sr[i] & (|rs) & (rs == bus.ex_rd);
        fwd_sel_enc #(.AW(AW)) u_enc (
            .rs(rs), .sr(bus.id_sr[i]),
            .ex_le(bus.ex_rf_le), .mem_le(bus.mem_rf_le), .wb_le(bus.wb_rf_le),
            .ex_rd(bus.ex_rd), .mem_rd(bus.mem_rd), .wb_rd(bus.wb_rd),
            .sel(fwd[2*i +: 2])
        );
    end
    assign hazard      = bus.ex_load & (|hit);
    assign bus.fwd_sel = fwd;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    // a hazard only needs the STALL state when more than one bubble is owed
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.mem_busy) begin
            if (bus.flush) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (state_q == IDLE) begin
                if (hazard && LOAD_LAT > 1) begin
                    state_d = STALL;
                    cnt_d   = CW'(LOAD_LAT - 2);
                end
            end else if (cnt_q == '0) begin
                state_d = IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end
    always_comb begin
        busy        = bus.mem_busy;
        stall_req   = !bus.flush & (hazard | (state_q == STALL));
        bus.nop     = !busy & (bus.flush | hazard | (state_q == STALL));
        bus.pc_le   = !busy & !stall_req;
        bus.id_le   = !busy & !stall_req;
        bus.pipe_le = !busy;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bubble_q <= '0;
        else if (bus.clr_stats)
            bubble_q <= '0;
        else if (bus.nop && bubble_q != '1)
            bubble_q <= bubble_q + CNT_W'(1);
    end
    assign bus.bubble_cnt = bubble_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb_hazard_ctrl_unit: directed vector table plus multi-cycle stall/freeze/flush/saturation sequences
module tb_hazard_ctrl_unit;
    logic clk, rst_n;
    int   total = 0, passed = 0;
    hazard_ctrl_unit_if #(.NSRC(2), .AW(5), .CNT_W(4)) bus ();
    hazard_ctrl_unit #(.NSRC(2), .AW(5), .LOAD_LAT(3), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    initial clk = 0;
    always #5 clk = ~clk;
    typedef struct {
        logic       ex_le, mem_le, wb_le;
        logic [4:0] ex_rd, mem_rd, wb_rd;
        logic       ld;
        logic [9:0] rs;
        logic [1:0] sr;
        logic [3:0] fwd;
        logic       nop;
        logic       id_le;
    } vec_t;
    vec_t vecs[8];
    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask
    task automatic zero_in;
        bus.ex_rf_le = 0; bus.mem_rf_le = 0; bus.wb_rf_le = 0;
        bus.ex_rd = 0; bus.mem_rd = 0; bus.wb_rd = 0; bus.ex_load = 0;
        bus.id_rs = 0; bus.id_sr = 0; bus.mem_busy = 0; bus.flush = 0; bus.clr_stats = 0;
    endtask
    task automatic do_reset;
        @(negedge clk);
        zero_in();
        rst_n = 0;
        #1 rst_n = 1;
    endtask
    task automatic load_use;
        bus.ex_load = 1; bus.ex_rf_le = 1; bus.ex_rd = 5'd4;
        bus.id_rs = {5'd4, 5'd0}; bus.id_sr = 2'b10;
    endtask
    task automatic outs(input string nm, input int nop, input int id_le, input int pipe_le);
        chk({nm, ".nop"}, int'(bus.nop), nop);
        chk({nm, ".id_le"}, int'(bus.id_le), id_le);
        chk({nm, ".pc_le"}, int'(bus.pc_le), id_le);
        chk({nm, ".pipe_le"}, int'(bus.pipe_le), pipe_le);
    endtask
    initial begin
        vecs[0] = '{1, 1, 0, 5'd7, 5'd7, 5'd0, 0, {5'd0, 5'd7},   2'b01, 4'b0001, 0, 1};
        vecs[1] = '{1, 0, 0, 5'd0, 5'd0, 5'd0, 1, {5'd0, 5'd0},   2'b01, 4'b0000, 0, 1};
        vecs[2] = '{1, 1, 1, 5'd9, 5'd3, 5'd3, 0, {5'd3, 5'd3},   2'b11, 4'b1010, 0, 1};
        vecs[3] = '{0, 1, 1, 5'd3, 5'd5, 5'd12, 0, {5'd12, 5'd3}, 2'b11, 4'b1100, 0, 1};
        vecs[4] = '{0, 0, 0, 5'd6, 5'd6, 5'd6, 0, {5'd0, 5'd6},   2'b01, 4'b0000, 0, 1};
        vecs[5] = '{0, 1, 0, 5'd4, 5'd4, 5'd0, 1, {5'd4, 5'd0},   2'b10, 4'b1000, 1, 0};
        vecs[6] = '{1, 0, 0, 5'd4, 5'd0, 5'd0, 1, {5'd4, 5'd8},   2'b01, 4'b0000, 0, 1};
        vecs[7] = '{1, 1, 0, 5'd31, 5'd31, 5'd0, 0, {5'd31, 5'd31}, 2'b11, 4'b0101, 0, 1};
        rst_n = 0;
        zero_in();
        #12 rst_n = 1;
        #1;
        outs("reset", 0, 1, 1);
        chk("reset.bubble_cnt", int'(bus.bubble_cnt), 0);
        chk("reset.fwd_sel", int'(bus.fwd_sel), 0);
        for (int i = 0; i < 8; i++) begin
            do_reset();
            bus.ex_rf_le = vecs[i].ex_le; bus.mem_rf_le = vecs[i].mem_le; bus.wb_rf_le = vecs[i].wb_le;
            bus.ex_rd = vecs[i].ex_rd; bus.mem_rd = vecs[i].mem_rd; bus.wb_rd = vecs[i].wb_rd;
            bus.ex_load = vecs[i].ld; bus.id_rs = vecs[i].rs; bus.id_sr = vecs[i].sr;
            #1;
            chk($sformatf("vec%0d.fwd_sel", i), int'(bus.fwd_sel), int'(vecs[i].fwd));
            outs($sformatf("vec%0d", i), int'(vecs[i].nop), int'(vecs[i].id_le), 1);
        end
        // three-bubble load-use stall
        do_reset();
        load_use();
        #1 outs("lu.b1", 1, 0, 1);
        @(negedge clk); bus.ex_load = 0;
        #2 outs("lu.b2", 1, 0, 1);
        @(negedge clk); #2 outs("lu.b3", 1, 0, 1);
        @(negedge clk); #2 outs("lu.rel", 0, 1, 1);
        chk("lu.bubble_cnt", int'(bus.bubble_cnt), 3);
        // memory wait freezes the stall mid-way
        do_reset();
        load_use();
        #1 outs("mb.b1", 1, 0, 1);
        @(negedge clk); bus.ex_load = 0; bus.mem_busy = 1;
        #2 outs("mb.frz1", 0, 0, 0);
        @(negedge clk); #2 outs("mb.frz2", 0, 0, 0);
        @(negedge clk); bus.mem_busy = 0;
        #2 outs("mb.b2", 1, 0, 1);
        @(negedge clk); #2 outs("mb.b3", 1, 0, 1);
        @(negedge clk); #2 outs("mb.rel", 0, 1, 1);
        chk("mb.bubble_cnt", int'(bus.bubble_cnt), 3);
        // flush releases the squashed consumer
        do_reset();
        load_use();
        #1 outs("fl.b1", 1, 0, 1);
        @(negedge clk); bus.ex_load = 0; bus.flush = 1;
        #2 outs("fl.b2", 1, 1, 1);
        @(negedge clk); bus.flush = 0;
        #2 outs("fl.idle", 0, 1, 1);
        chk("fl.bubble_cnt", int'(bus.bubble_cnt), 2);
        // reset in the middle of a stall
        @(negedge clk); load_use();
        #2 outs("rs.b1", 1, 0, 1);
        @(negedge clk); bus.ex_load = 0; rst_n = 0;
        #2 outs("rs.inrst", 0, 1, 1);
        chk("rs.bubble_cnt", int'(bus.bubble_cnt), 0);
        @(negedge clk); rst_n = 1;
        #2 outs("rs.after", 0, 1, 1);
        // bubble counter saturation and clear
        do_reset();
        load_use();
        for (int c = 0; c < 20; c++) begin
            #1 chk($sformatf("sat.nop%0d", c), int'(bus.nop), 1);
            @(negedge clk);
        end
        bus.clr_stats = 1;
        #2 chk("sat.bubble_cnt", int'(bus.bubble_cnt), 15);
        @(negedge clk); bus.clr_stats = 0; bus.ex_load = 0;
        #2 chk("clr.bubble_cnt", int'(bus.bubble_cnt), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
